wshb_rr_arbiter: RTL and testbench

Round-robin Wishbone (classic) arbiter that shares one framebuffer SDRAM slave port between NM masters, e.g. the test-pattern writer and the video scanout reader.
Grants whole cycles (cyc-framed) with a configurable preemption cap, so a long writer burst cannot starve display refill.
Sits between the pattern/video masters and the SDRAM controller's Wishbone slave, all in the same clock domain.

---
 rtl/wshb_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 38 +++
 rtl/wshb_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wshb_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wshb_arb_pkg
// Brief    : Shared types and Wishbone field widths for the round-robin
//            Wishbone arbiter and its picker.
// Revision : 1.0 - initial release
// ============================================================================
package wshb_arb_pkg;

    // Wishbone classic field widths (data bus fixed at 32 bits)
    localparam int DW     = 32;
    localparam int SW     = 4;
    localparam int CTIW   = 3;
    localparam int BTEW   = 2;

    // Largest supported master count; sizes the owner/pointer index
    localparam int MAX_NM = 8;

    typedef logic [$clog2(MAX_NM)-1:0] owner_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Returns the first requester
//            found searching ptr+1, ptr+2, ... modulo NM.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import wshb_arb_pkg::*;
#(
    parameter int NM = 2
) (
    input  logic [NM-1:0] req_i,
    input  owner_t        ptr_i,
    output logic [NM-1:0] gnt_o,
    output owner_t        idx_o,
    output logic          valid_o
);

    logic [NM-1:0] w_rot;
    int            w_sel;

    // Rotate so slot ptr+1 lands at bit 0, then take the lowest set bit.
    always_comb begin
        w_rot = NM'({req_i, req_i} >> (int'(ptr_i) + 1));
        w_sel = 0;
        for (int j = NM - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_sel = j;
            end
        end
        idx_o   = owner_t'((int'(ptr_i) + 1 + w_sel) % NM);
        gnt_o   = {{(NM-1){1'b0}}, 1'b1} << idx_o;
        valid_o = |req_i;
    end

endmodule
`default_nettype wire

// File: rtl/wshb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wshb_rr_arbiter
// Brief    : Round-robin Wishbone classic arbiter sharing one slave port
//            between NM masters, with whole-cycle grants and an optional
//            per-owner ack cap that forces a handover when others wait.
// Revision : 1.0 - initial release
// ============================================================================
module wshb_rr_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int NM        = 2,
    parameter int MAX_BURST = 64,
    parameter int AW        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NM-1:0]        m_cyc,
    input  logic [NM-1:0]        m_stb,
    input  logic [NM-1:0]        m_we,
    input  logic [NM*AW-1:0]     m_adr,
    input  logic [NM*DW-1:0]     m_dat_ms,
    input  logic [NM*SW-1:0]     m_sel,
    input  logic [NM*CTIW-1:0]   m_cti,
    input  logic [NM*BTEW-1:0]   m_bte,
    output logic [NM-1:0]        m_ack,
    output logic [DW-1:0]        m_dat_sm,
    output logic                 s_cyc,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [AW-1:0]        s_adr,
    output logic [DW-1:0]        s_dat_ms,
    output logic [SW-1:0]        s_sel,
    output logic [CTIW-1:0]      s_cti,
    output logic [BTEW-1:0]      s_bte,
    input  logic                 s_ack,
    input  logic [DW-1:0]        s_dat_sm,
    output logic [NM-1:0]        gnt
);

    localparam int             BCW       = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BCW-1:0] BURST_CAP = BCW'(MAX_BURST);

    arb_state_e     state_q, state_d;
    logic [NM-1:0]  own_oh_q, own_oh_d;
    owner_t         own_idx_q, own_idx_d;
    owner_t         ptr_q, ptr_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic           busy_q, busy_d;

    logic           w_own_cyc;
    logic           w_own_stb;
    logic [NM-1:0]  w_others;
    logic           w_hold;
    logic           w_xfer;
    logic [NM-1:0]  w_pick_req;
    owner_t         w_pick_ptr;
    logic [NM-1:0]  w_pick_gnt;
    owner_t         w_pick_idx;
    logic           w_pick_valid;

    // Idle: search from the last-served master; owned: search the others from the owner.
    assign w_pick_req = (state_q == ST_IDLE) ? m_cyc : w_others;
    assign w_pick_ptr = (state_q == ST_IDLE) ? ptr_q : own_idx_q;

    rr_pick #(
        .NM      (NM)
    ) u_rr_pick (
        .req_i   (w_pick_req),
        .ptr_i   (w_pick_ptr),
        .gnt_o   (w_pick_gnt),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

    // Select the owner's Wishbone fields; all zero while no one owns the port.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_ms  = '0;
        s_sel     = '0;
        s_cti     = '0;
        s_bte     = '0;
        for (int i = 0; i < NM; i++) begin
            if (own_oh_q[i]) begin
                w_own_cyc = m_cyc[i];
                w_own_stb = m_stb[i];
                s_we      = m_we[i];
                s_adr     = m_adr[i*AW +: AW];
                s_dat_ms  = m_dat_ms[i*DW +: DW];
                s_sel     = m_sel[i*SW +: SW];
                s_cti     = m_cti[i*CTIW +: CTIW];
                s_bte     = m_bte[i*BTEW +: BTEW];
            end
        end
    end

    // Hold masks the owner once its cap is spent and someone else waits; it never
    // cuts a strobe the slave has already seen without acking (busy_q).
    assign w_others = m_cyc & ~own_oh_q;
    assign w_hold   = (MAX_BURST > 0) && (state_q == ST_OWNED) && (bcnt_q == BURST_CAP)
                      && (|w_others) && !busy_q;
    assign s_cyc    = (state_q == ST_OWNED) & w_own_cyc & ~w_hold;
    assign s_stb    = s_cyc & w_own_stb;
    assign w_xfer   = s_stb & s_ack;
    assign m_ack    = own_oh_q & {NM{w_xfer}};
    assign m_dat_sm = s_dat_sm;
    assign gnt      = own_oh_q;
    assign busy_d   = s_stb & ~s_ack;

    // Ownership next-state: grant from idle, release on cyc drop or preemption, count acks.
    always_comb begin
        state_d   = state_q;
        own_oh_d  = own_oh_q;
        own_idx_d = own_idx_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    state_d   = ST_OWNED;
                    own_oh_d  = w_pick_gnt;
                    own_idx_d = w_pick_idx;
                    bcnt_d    = '0;
                end
            end
            ST_OWNED: begin
                if (!w_own_cyc || w_hold) begin
                    ptr_d  = own_idx_q;
                    bcnt_d = '0;
                    if (w_pick_valid) begin
                        own_oh_d  = w_pick_gnt;
                        own_idx_d = w_pick_idx;
                    end else begin
                        state_d  = ST_IDLE;
                        own_oh_d = '0;
                    end
                end else if (w_xfer && (bcnt_q != BURST_CAP)) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                own_oh_d = '0;
            end
        endcase
    end

    // State registers; reset gives master 0 first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            own_oh_q  <= '0;
            own_idx_q <= '0;
            ptr_q     <= owner_t'(NM - 1);
            bcnt_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_oh_q  <= own_oh_d;
            own_idx_q <= own_idx_d;
            ptr_q     <= ptr_d;
            bcnt_q    <= bcnt_d;
            busy_q    <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wshb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_rr_arbiter
// Brief    : Self-checking bench for wshb_rr_arbiter (NM=2, MAX_BURST=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_rr_arbiter;

    localparam int NM = 2;
    localparam int MB = 4;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*32-1:0]  m_dat_ms;
    logic [NM*4-1:0]   m_sel;
    logic [NM*3-1:0]   m_cti;
    logic [NM*2-1:0]   m_bte;
    logic [NM-1:0]     m_ack;
    logic [31:0]       m_dat_sm;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [31:0]       s_dat_ms;
    logic [3:0]        s_sel;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic              s_ack;
    logic [31:0]       s_dat_sm;
    logic [NM-1:0]     gnt;

    int errors = 0;
    int checks = 0;

    // Reference model: owner (-1 = idle), last-served master, acks this tenure,
    // and whether a strobe was left unacknowledged last cycle.
    int            mo_own, mo_ptr, mo_cnt;
    bit            mo_busy;
    int            nx_own, nx_ptr, nx_cnt;
    bit            nx_busy;
    logic [NM-1:0] e_gnt, e_mack;
    logic          e_scyc, e_sstb;

    always #5 clk = ~clk;

    wshb_rr_arbiter #(.NM(NM), .MAX_BURST(MB), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_dat_sm(s_dat_sm), .gnt(gnt)
    );

    // First master with cyc high after 'from' in circular order, skipping 'excl'.
    function automatic int rr_first(int from, int excl);
        for (int k = 1; k <= NM; k++) begin
            int c;
            c = (from + k) % NM;
            if (c != excl && m_cyc[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_eval();
        bit others, hold;
        others = 1'b0;
        for (int j = 0; j < NM; j++) if (j != mo_own && m_cyc[j]) others = 1'b1;
        hold   = (mo_own >= 0) && (MB > 0) && (mo_cnt >= MB) && others && !mo_busy;
        e_gnt  = '0;
        e_mack = '0;
        e_scyc = 1'b0;
        e_sstb = 1'b0;
        if (mo_own >= 0) begin
            e_gnt[mo_own] = 1'b1;
            e_scyc = m_cyc[mo_own] && !hold;
            e_sstb = e_scyc && m_stb[mo_own];
            if (e_sstb && s_ack) e_mack[mo_own] = 1'b1;
        end
        nx_own  = mo_own;
        nx_ptr  = mo_ptr;
        nx_cnt  = mo_cnt;
        nx_busy = e_sstb && !s_ack;
        if (!rst_n) begin
            nx_own = -1; nx_ptr = NM - 1; nx_cnt = 0; nx_busy = 1'b0;
        end else if (mo_own < 0) begin
            nx_own = rr_first(mo_ptr, -1);
            nx_cnt = 0;
        end else if (!m_cyc[mo_own] || hold) begin
            nx_ptr = mo_own;
            nx_cnt = 0;
            nx_own = rr_first(mo_own, mo_own);
        end else if (e_sstb && s_ack && mo_cnt < MB) begin
            nx_cnt = mo_cnt + 1;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        mo_own = nx_own; mo_ptr = nx_ptr; mo_cnt = nx_cnt; mo_busy = nx_busy;
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_ms = '0;
        m_sel = '1; m_cti = '0; m_bte = '0; s_ack = 1'b0; s_dat_sm = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        settle(); advance();
        settle(); advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        m_cyc = '1; m_stb = '1; s_ack = 1'b1; rst_n = 1'b0;
        settle(); advance();
        settle();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc); end
        checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %b expected 0", s_stb); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset_m_ack: got %b expected 00", m_ack); end
        rst_n = 1'b1; m_cyc = '0; m_stb = '0;
        advance();
    endtask

    task automatic test_first_grant();
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11;
        m_adr = {32'hB000_0004, 32'hA000_0000};
        settle();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL grant_latency: got %b expected 00", gnt); end
        advance(); settle();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL first_grant: got %b expected 01", gnt); end
        checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1) begin errors++; $display("FAIL first_grant_cyc_stb: got %b%b expected 11", s_cyc, s_stb); end
        checks++; if (s_adr !== 32'hA000_0000) begin errors++; $display("FAIL first_grant_adr: got %h expected a0000000", s_adr); end
    endtask

    task automatic test_handover();
        int acks, bad1, n;
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; s_ack = 1'b1;
        acks = 0; bad1 = 0; n = 0;
        while (acks < 8 && n < 40) begin
            m_adr[31:0] = 32'(acks * 4);
            m_dat_ms[31:0] = $urandom;
            settle();
            if (m_ack[0]) acks++;
            if (m_ack[1]) bad1++;
            advance();
            n++;
        end
        m_cyc = 2'b10; m_stb = 2'b10;
        settle();
        checks++; if (gnt !== 2'b01 || s_cyc !== 1'b0) begin errors++; $display("FAIL handover_drop: gnt %b s_cyc %b expected 01 0", gnt, s_cyc); end
        advance(); settle();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL handover_gnt: got %b expected 10", gnt); end
        checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL handover_s_cyc: got %b expected 1", s_cyc); end
        checks++; if (acks != 8) begin errors++; $display("FAIL handover_ack_count: got %0d expected 8", acks); end
        checks++; if (bad1 != 0) begin errors++; $display("FAIL handover_stray_ack: got %0d expected 0", bad1); end
    endtask

    task automatic test_preempt();
        int seq[$];
        int leak, bad, first_bad;
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11; s_ack = 1'b1;
        leak = 0;
        for (int c = 0; c < 60; c++) begin
            settle();
            if ((m_ack & ~gnt) != 0 || $countones(m_ack) > 1) leak++;
            if (m_ack == 2'b01) seq.push_back(0);
            else if (m_ack == 2'b10) seq.push_back(1);
            advance();
        end
        bad = 0; first_bad = -1;
        foreach (seq[k]) if (seq[k] != (k / MB) % 2) begin bad++; if (first_bad < 0) first_bad = k; end
        checks++; if (seq.size() < 40) begin errors++; $display("FAIL preempt_ack_total: got %0d expected >=40", seq.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL preempt_order: got %0d wrong owners (first at ack %0d) expected 0", bad, first_bad); end
        checks++; if (leak != 0) begin errors++; $display("FAIL preempt_ack_leak: got %0d expected 0", leak); end
    endtask

    task automatic test_no_preempt();
        int acks, gbad, c;
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; s_ack = 1'b1;
        acks = 0; gbad = 0; c = 0;
        while (acks < 100 && c < 300) begin
            settle();
            if (m_ack[0]) acks++;
            if (c > 0 && gnt !== 2'b01) gbad++;
            advance();
            c++;
        end
        checks++; if (acks != 100) begin errors++; $display("FAIL solo_ack_count: got %0d expected 100", acks); end
        checks++; if (gbad != 0) begin errors++; $display("FAIL solo_gnt_stable: got %0d bad cycles expected 0", gbad); end
    endtask

    task automatic test_read();
        do_reset();
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b00;
        m_adr[63:32] = 32'h0000_1000; s_dat_sm = 32'hDEADBEEF;
        settle(); advance(); settle();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL read_gnt: got %b expected 10", gnt); end
        checks++; if (s_we !== 1'b0 || s_adr !== 32'h0000_1000) begin errors++; $display("FAIL read_fields: we %b adr %h expected 0 00001000", s_we, s_adr); end
        s_ack = 1'b1;
        settle();
        checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL read_m_ack: got %b expected 10", m_ack); end
        checks++; if (m_dat_sm !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", m_dat_sm); end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; s_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin settle(); advance(); end
        rst_n = 1'b0; s_ack = 1'b0;
        settle(); advance();
        rst_n = 1'b1; m_cyc = 2'b11; m_stb = 2'b11;
        settle();
        checks++; if (s_cyc !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL midreset_idle: s_cyc %b gnt %b expected 0 00", s_cyc, gnt); end
        advance(); settle();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midreset_regrant: got %b expected 01", gnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int j = 0; j < NM; j++) begin
                if ($urandom_range(0, 7) == 0) m_cyc[j] = ~m_cyc[j];
                m_stb[j] = m_cyc[j] & ($urandom_range(0, 3) != 0);
                m_we[j]  = 1'($urandom);
                m_adr[j*AW +: AW]  = $urandom;
                m_dat_ms[j*32 +: 32] = $urandom;
                m_sel[j*4 +: 4] = 4'($urandom);
                m_cti[j*3 +: 3] = 3'($urandom);
                m_bte[j*2 +: 2] = 2'($urandom);
            end
            s_ack    = 1'($urandom);
            s_dat_sm = $urandom;
            rst_n    = ($urandom_range(0, 199) != 0);
            settle();
            checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, gnt, e_gnt); end
            checks++; if (s_cyc !== e_scyc || s_stb !== e_sstb) begin errors++; $display("FAIL rnd_cyc_stb c%0d: got %b%b expected %b%b", c, s_cyc, s_stb, e_scyc, e_sstb); end
            checks++; if (m_ack !== e_mack) begin errors++; $display("FAIL rnd_m_ack c%0d: got %b expected %b", c, m_ack, e_mack); end
            checks++; if (m_dat_sm !== s_dat_sm) begin errors++; $display("FAIL rnd_dat_sm c%0d: got %h expected %h", c, m_dat_sm, s_dat_sm); end
            if (e_scyc) begin
                checks++;
                if (s_adr !== m_adr[mo_own*AW +: AW] || s_dat_ms !== m_dat_ms[mo_own*32 +: 32] ||
                    s_we !== m_we[mo_own] || s_sel !== m_sel[mo_own*4 +: 4] ||
                    s_cti !== m_cti[mo_own*3 +: 3] || s_bte !== m_bte[mo_own*2 +: 2]) begin
                    errors++;
                    $display("FAIL rnd_fields c%0d: adr %h dat %h we %b sel %h cti %h bte %h expected from master %0d adr %h dat %h",
                             c, s_adr, s_dat_ms, s_we, s_sel, s_cti, s_bte, mo_own,
                             m_adr[mo_own*AW +: AW], m_dat_ms[mo_own*32 +: 32]);
                end
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        mo_own = -1; mo_ptr = NM - 1; mo_cnt = 0; mo_busy = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_first_grant();
        test_handover();
        test_preempt();
        test_no_preempt();
        test_read();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
